// File: rtl/accum_seq_if.sv
// Command/result bus for accum_seq plus the port to the external adder/subtractor.
// slave is the accumulator side; master is the environment that drives commands and the adder.
interface accum_seq_if #(
  parameter int dw = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [dw-1:0] in_data;
  logic [dw-1:0] as_dataa;
  logic [dw-1:0] as_datab;
  logic          as_add_sub;
  logic [dw-1:0] as_result;
  logic          out_valid;
  logic          out_ready;
  logic [dw-1:0] out_data;
  logic          out_ovf;
  logic          ovf_sticky;
  logic [7:0]    op_count;

  modport slave (
    input  in_valid, in_op, in_data, as_result, out_ready,
    output in_ready, as_dataa, as_datab, as_add_sub,
           out_valid, out_data, out_ovf, ovf_sticky, op_count
  );

  modport master (
    output in_valid, in_op, in_data, as_result, out_ready,
    input  in_ready, as_dataa, as_datab, as_add_sub,
           out_valid, out_data, out_ovf, ovf_sticky, op_count
  );
endinterface

// File: rtl/accum_seq.sv
// Accumulator sequencer: one command in, arithmetic via an external adder, one result out.
// Accept at edge N, result valid after N+1, held until out_ready; next accept at N+3 at best.
module accum_seq #(
  parameter int dw = 8
) (
  input  logic       clk,
  input  logic       reset,
  accum_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, OUT = 2'd2} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;

  state_t        state_q, state_d;
  logic [dw-1:0] acc_q, acc_d;
  logic [dw-1:0] opnd_q, opnd_d;
  logic [1:0]    op_q, op_d;
  logic          ovf_q, ovf_d;
  logic          sticky_q, sticky_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          add_ovf, sub_ovf;
  logic [7:0]    cnt_inc;

  // Signed overflow from sign bits of both operands and the returned result.
  assign add_ovf = (acc_q[dw-1] == opnd_q[dw-1]) && (bus.as_result[dw-1] != acc_q[dw-1]);
  assign sub_ovf = (acc_q[dw-1] != opnd_q[dw-1]) && (bus.as_result[dw-1] != acc_q[dw-1]);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    ovf_d       = ovf_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d       = bus.in_op;
          opnd_d     = bus.in_data;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        case (op_q)
          OP_LOAD: begin
            acc_d    = opnd_q;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
            cnt_d    = cnt_inc;
          end
          OP_ADD: begin
            acc_d    = bus.as_result;
            ovf_d    = add_ovf;
            sticky_d = sticky_q | add_ovf;
            cnt_d    = cnt_inc;
          end
          OP_SUB: begin
            acc_d    = bus.as_result;
            ovf_d    = sub_ovf;
            sticky_d = sticky_q | sub_ovf;
            cnt_d    = cnt_inc;
          end
          default: begin
            acc_d    = '0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
            cnt_d    = 8'd1;
          end
        endcase
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      op_q        <= OP_LOAD;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = acc_q;
  assign bus.out_ovf    = ovf_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.op_count   = cnt_q;
  assign bus.as_dataa   = acc_q;
  assign bus.as_datab   = opnd_q;
  // Subtract only while a SUB is being evaluated; add everywhere else.
  assign bus.as_add_sub = !((state_q == CALC) && (op_q == OP_SUB));
endmodule

// File: tb/tb_accum_seq.sv
// Bench for accum_seq: directed vector table, hand-written corner sequences, random commands vs model.
module tb_accum_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  accum_seq_if #(.dw(8)) bus ();

  accum_seq #(.dw(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External adder/subtractor.
  assign bus.as_result = bus.as_add_sub ? (bus.as_dataa + bus.as_datab)
                                        : (bus.as_dataa - bus.as_datab);

  // Reference model state.
  logic [7:0] m_acc;
  logic       m_ovf, m_sticky;
  int         m_cnt;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] e_data;
    logic       e_ovf;
    logic       e_sticky;
    logic [7:0] e_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 8'h00; m_ovf = 1'b0; m_sticky = 1'b0; m_cnt = 0;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [7:0] data);
    int s;
    case (op)
      2'b00: begin m_acc = data; m_ovf = 1'b0; m_sticky = 1'b0; end
      2'b01: begin
        s = int'($signed(m_acc)) + int'($signed(data));
        m_ovf = (s > 127) || (s < -128);
        m_acc = m_acc + data;
        m_sticky = m_sticky | m_ovf;
      end
      2'b10: begin
        s = int'($signed(m_acc)) - int'($signed(data));
        m_ovf = (s > 127) || (s < -128);
        m_acc = m_acc - data;
        m_sticky = m_sticky | m_ovf;
      end
      default: begin m_acc = 8'h00; m_ovf = 1'b0; m_sticky = 1'b0; end
    endcase
    if (op == 2'b11) m_cnt = 1;
    else if (m_cnt < 255) m_cnt = m_cnt + 1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  // Issue one command, check handshake timing and output hold, return the observed result.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input int stall,
                         output logic [7:0] r_data, output logic r_ovf, output logic r_sticky,
                         output logic [7:0] r_cnt);
    bus.in_op = op; bus.in_data = data; bus.in_valid = 1'b1;
    bus.out_ready = (stall == 0);
    wait_ready();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("calc_out_valid", 32'(bus.out_valid), 32'd0);
    chk("calc_in_ready", 32'(bus.in_ready), 32'd0);
    chk("calc_add_sub", 32'(bus.as_add_sub), 32'(op != 2'b10));
    @(posedge clk); #1;
    chk("out_valid_latency", 32'(bus.out_valid), 32'd1);
    r_data = bus.out_data; r_ovf = bus.out_ovf; r_sticky = bus.ovf_sticky; r_cnt = bus.op_count;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", 32'(bus.out_data), 32'(r_data));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", 32'(bus.in_ready), 32'd1);
    chk("valid_dropped", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_vs_model(input logic [1:0] op, input logic [7:0] data, input int stall,
                              input string tag);
    logic [7:0] d, c;
    logic o, s;
    run_cmd(op, data, stall, d, o, s, c);
    model_apply(op, data);
    chk({tag, "_data"}, 32'(d), 32'(m_acc));
    chk({tag, "_ovf"}, 32'(o), 32'(m_ovf));
    chk({tag, "_sticky"}, 32'(s), 32'(m_sticky));
    chk({tag, "_cnt"}, 32'(c), 32'(m_cnt));
  endtask

  initial begin
    vec_t vecs[11];
    logic [7:0] d, c, hold_d;
    logic o, s;

    vecs[0]  = '{2'b00, 8'h05, 8'h05, 1'b0, 1'b0, 8'd1};
    vecs[1]  = '{2'b01, 8'h03, 8'h08, 1'b0, 1'b0, 8'd2};
    vecs[2]  = '{2'b00, 8'h7F, 8'h7F, 1'b0, 1'b0, 8'd3};
    vecs[3]  = '{2'b01, 8'h01, 8'h80, 1'b1, 1'b1, 8'd4};
    vecs[4]  = '{2'b01, 8'h01, 8'h81, 1'b0, 1'b1, 8'd5};
    vecs[5]  = '{2'b00, 8'h80, 8'h80, 1'b0, 1'b0, 8'd6};
    vecs[6]  = '{2'b10, 8'h01, 8'h7F, 1'b1, 1'b1, 8'd7};
    vecs[7]  = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'd8};
    vecs[8]  = '{2'b10, 8'h01, 8'hFF, 1'b0, 1'b0, 8'd9};
    vecs[9]  = '{2'b11, 8'hEE, 8'h00, 1'b0, 1'b0, 8'd1};
    vecs[10] = '{2'b01, 8'h01, 8'h01, 1'b0, 1'b0, 8'd2};

    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_data = 8'h00; bus.out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_ovf", 32'(bus.out_ovf), 32'd0);
    chk("rst_sticky", 32'(bus.ovf_sticky), 32'd0);
    chk("rst_cnt", 32'(bus.op_count), 32'd0);

    // Directed vector table.
    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].data, 0, d, o, s, c);
      model_apply(vecs[i].op, vecs[i].data);
      chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_sticky", i), 32'(s), 32'(vecs[i].e_sticky));
      chk($sformatf("vec%0d_cnt", i), 32'(c), 32'(vecs[i].e_cnt));
    end

    // Backpressure: result held, a waiting command is not captured until after the handshake.
    bus.in_op = 2'b01; bus.in_data = 8'h11; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    wait_ready();
    @(posedge clk); #1;
    model_apply(2'b01, 8'h11);
    bus.in_op = 2'b00; bus.in_data = 8'hAA;
    @(posedge clk); #1;
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_data", 32'(bus.out_data), 32'(m_acc));
    hold_d = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.out_data), 32'(hold_d));
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_acc_untouched", 32'(bus.out_data), 32'(hold_d));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model_apply(2'b00, 8'hAA);
    @(posedge clk); #1;
    chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_second_data", 32'(bus.out_data), 32'h000000AA);
    @(posedge clk); #1;

    // Reset in the middle of an ADD evaluation.
    run_vs_model(2'b00, 8'h20, 0, "pre_rst");
    bus.in_op = 2'b01; bus.in_data = 8'h10; bus.in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_calc_data", 32'(bus.out_data), 32'd0);
    chk("rst_calc_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_calc_cnt", 32'(bus.op_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("rst_calc_ready", 32'(bus.in_ready), 32'd1);
    run_vs_model(2'b00, 8'h33, 0, "post_rst");

    // Reset while the result is waiting for out_ready.
    bus.in_op = 2'b01; bus.in_data = 8'h01; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    wait_ready();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("out_state_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_out_drop", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();

    // 300 non-CLEAR commands drive op_count into saturation.
    for (int i = 0; i < 300; i++)
      run_vs_model(2'($urandom_range(0, 2)), 8'($urandom), 0, "sat");
    chk("sat_cnt_255", 32'(bus.op_count), 32'd255);
    run_vs_model(2'b11, 8'($urandom), 0, "clear");
    chk("clear_cnt_1", 32'(bus.op_count), 32'd1);
    chk("clear_data_0", 32'(bus.out_data), 32'd0);

    // Random mix of all ops with random backpressure.
    for (int i = 0; i < 120; i++)
      run_vs_model(2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)), "rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/accum_seq.md
ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 SHALL have parameter: dw, default 8, data width of accumulator, operands and add/sub port.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-004 SHALL have in_valid  input  1  command present.
REQ-005 SHALL have in_ready  output  1  command accepted when in_valid&&in_ready at rising edge.
REQ-006 SHALL have in_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-007 SHALL have in_data  input  dw  command operand (ignored for CLEAR).
REQ-008 SHALL have as_dataa  output  dw  to downstream adder/subtractor, first operand.
REQ-009 SHALL have as_datab  output  dw  to adder/subtractor, second operand.
REQ-010 SHALL have as_add_sub  output  1  to adder/subtractor; 1 add, 0 subtract.
REQ-011 SHALL have as_result  input  dw  combinational result returned by adder/subtractor.
REQ-012 SHALL have out_valid  output  1  result available.
REQ-013 SHALL have out_ready  input  1  consumer takes result when out_valid&&out_ready at rising edge.
REQ-014 SHALL have out_data  output  dw  accumulator value.
REQ-015 SHALL have out_ovf  output  1  signed overflow of the last completed op.
REQ-016 SHALL have ovf_sticky  output  1  set by any overflow since last LOAD/CLEAR.
REQ-017 SHALL have op_count  output  8  completed commands since reset/CLEAR, saturating at 255.

Function
REQ-018 SHALL implement FSM states IDLE, CALC, OUT; one-hot or binary encoding at implementer's choice.
REQ-019 IDLE: in_ready=1, out_valid=0; on handshake register in_op/in_data into op_r/opnd_r, go CALC.
REQ-020 CALC: in_ready=0, out_valid=0; as_dataa=acc, as_datab=opnd_r, as_add_sub=1 unless op_r==SUB; at edge go OUT.
REQ-021 CALC edge: acc <= opnd_r (LOAD), as_result (ADD/SUB), 0 (CLEAR).
REQ-022 Outside CALC, as_dataa=acc, as_datab=opnd_r, as_add_sub=1 (stable, no glitch requirement).
REQ-023 out_ovf, updated at CALC edge: ADD -> acc[dw-1]==opnd_r[dw-1] && as_result[dw-1]!=acc[dw-1]; SUB -> acc[dw-1]!=opnd_r[dw-1] && as_result[dw-1]!=acc[dw-1]; LOAD/CLEAR -> 0.
REQ-024 ovf_sticky: cleared at CALC edge for LOAD/CLEAR, else OR-ed with new out_ovf.
REQ-025 op_count: CLEAR sets to 1 at CALC edge; other ops increment, saturate at 255.
REQ-026 OUT: out_valid=1, out_data=acc, in_ready=0; hold all outputs stable until out_ready; on out_valid&&out_ready go IDLE.
REQ-027 Latency: command accepted at edge N -> out_valid high after edge N+1; earliest next accept at edge N+3 (out_ready held 1).
REQ-028 Arithmetic wraps modulo 2^dw; no saturation of acc.
REQ-029 in_valid during CALC/OUT SHALL be ignored (not captured); upstream holds command until in_ready.
REQ-030 out_data SHALL equal acc in all states (valid only qualified by out_valid).

Reset
REQ-031 On reset: state=IDLE, acc=0, op_r=00, opnd_r=0, out_ovf=0, ovf_sticky=0, op_count=0, out_valid=0, in_ready=1 (after release).
REQ-032 Reset asserted mid-CALC or mid-OUT SHALL abort the command with no acc update and drop out_valid immediately.
REQ-033 First command SHALL be accepted at first rising edge after reset deasserts if in_valid=1.

Verification
REQ-034 LOAD 0x05, ADD 0x03, out_ready=1 -> out_data 0x05 then 0x08; out_ovf 0; op_count 2.
REQ-035 LOAD 0x7F, ADD 0x01 -> out_data 0x80, out_ovf 1, ovf_sticky 1; then ADD 0x01 -> 0x81, out_ovf 0, ovf_sticky stays 1.
REQ-036 LOAD 0x80, SUB 0x01 -> out_data 0x7F, out_ovf 1; LOAD 0x00, SUB 0x01 -> 0xFF, out_ovf 0, ovf_sticky 0.
REQ-037 Backpressure: out_ready=0 for 5 cycles after ADD -> out_valid and out_data held, in_ready 0, second in_valid not captured until after handshake.
REQ-038 Reset pulse during CALC of ADD 0x10 on acc 0x20 -> acc 0x00, out_valid 0, op_count 0; next LOAD 0x33 returns 0x33.
REQ-039 CLEAR after 300 commands -> op_count saturates 255 before, reads 1 after CLEAR; out_data 0x00.
